lfsr_range_sampler: RTL and testbench
=====================================

Name: lfsr_range_sampler

Overview:
Consumes the free-running 32-bit LFSR state and produces uniformly distributed integers in [0, limit) using mask-and-reject sampling. Accepted samples are buffered in a small FIFO. The FIFO drains over a valid/ready handshake to downstream consumers such as dither and random-event logic. The block sits directly downstream of the LFSR; one LFSR state is examined per clock.

Parameters:
OUT_W, 8, width of the sample and of the limit; legal range 1..16.
FIFO_DEPTH, 4, output buffer entries; power of two, at least 2.

Ports:
clk_i  input  1  clock; all state updates on the rising edge.
reset_i  input  1  asynchronous, active-high reset.
lfsr_state_i  input  32  current LFSR state; a new value arrives every cycle.
enable_i  input  1  sampling enable.
limit_i  input  OUT_W  exclusive upper bound; 0 means no sampling.
rand_o  output  OUT_W  head of the FIFO.
valid_o  output  1  rand_o holds a sample.
ready_i  input  1  consumer accepts the head this cycle.
reject_cnt_o  output  16  count of rejected candidates (optional feature).

Behaviour:
- Reset: FSM goes to IDLE, the FIFO empties, limit_q=0, valid_o=0, rand_o=0, reject_cnt_o=0. Reset takes effect asynchronously, including mid-operation.
- mask = smallest 2^k-1 that is >= limit_q-1. limit_q=1 gives mask=0.
- candidate = lfsr_state_i[OUT_W-1:0] & mask.
- FSM states:
  - IDLE: move to FLUSH when enable_i=1 and limit_i!=0.
  - FLUSH (exactly one cycle): clears the FIFO, loads limit_q<=limit_i, takes no sample. Next state is RUN.
  - RUN:
    - If enable_i=0 or limit_i==0, go to IDLE. The FIFO is retained and keeps draining.
    - Else if limit_i!=limit_q, go to FLUSH. Queued samples are discarded and valid_o is 0 for that cycle.
    - Otherwise sample.
- Sampling in RUN:
  - A candidate is taken only if the FIFO count < FIFO_DEPTH, using the registered count. There is no pass-through on full, even if a pop happens the same cycle.
  - candidate < limit_q: push.
  - candidate >= limit_q: drop and increment the reject counter.
  - A full FIFO does not count as a rejection.
- Latency: a candidate accepted in cycle t is visible on rand_o/valid_o in cycle t+1 when the FIFO was empty.
- Handshake: pop happens when valid_o&ready_i. rand_o and valid_o stay stable until popped. Push and pop in the same cycle are both honoured and leave the count unchanged.
- The FIFO pointers wrap modulo FIFO_DEPTH. The count has log2(FIFO_DEPTH)+1 bits.
- valid_o and rand_o are registered or driven from FIFO storage, never combinationally from lfsr_state_i.

Optional Feature:
LFSR_SAMPLER_STATS_EN
- Defined: 16-bit saturating reject counter, cleared by reset and on every FLUSH; driven on reject_cnt_o.
- Undefined: no counter logic; reject_cnt_o is tied to 0.

Decomposition:
- Package lfsr_pkg:
  - LFSR_W=32.
  - Sampler state enum {IDLE, FLUSH, RUN}.
  - Function range_mask(limit, width).
- Sub-module lfsr_sampler_fifo: synchronous FIFO with push, pop, flush, full, empty, count; parameters WIDTH and DEPTH.

Test Plan:
- Reset check: assert reset_i -> valid_o=0, rand_o=0, reject_cnt_o=0 immediately, without waiting for a clock edge.
- Rejection: limit_i=200, enable_i=1, ready_i=1; after FLUSH drive lfsr_state_i=0x00B41BFD then 0x00000042.
  - 0xFD (253) is rejected; reject_cnt_o=1 with STATS_EN.
  - rand_o=0x42 with valid_o=1 on the following cycle.
- Degenerate limit: limit_i=1, random lfsr_state_i -> every output is 0 and reject_cnt_o stays 0.
- Backpressure: limit_i=16, ready_i=0; drive states with low bytes 0x13, 0x25, 0x07, 0x39, 0x0B.
  - The FIFO holds 3, 5, 7, 9; 0x0B is not taken.
  - Then ready_i=1 -> outputs 3, 5, 7, 9 in order, then valid_o=0.
- Limit change: 2 entries queued at limit 16, then limit_i=10 -> valid_o=0 for one cycle, FIFO empty, and all later outputs are < 10.
- Disable: drop enable_i with 3 entries queued -> state IDLE, the 3 entries still drain, and no new pushes occur.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the LFSR range sampler.
// The mask helper turns an exclusive bound into the smallest all-ones mask covering it.
package lfsr_pkg;

    localparam int LFSR_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        RUN   = 2'd2
    } sampler_state_e;

    // Smallest 2^k-1 that is >= limit-1, clipped to the sample width; limit 0 or 1 gives 0.
    function automatic logic [15:0] range_mask(input logic [15:0] limit, input int width);
        logic [15:0] need;
        logic [15:0] m;
        need = (limit == 16'd0) ? 16'd0 : (limit - 16'd1);
        m    = 16'd0;
        for (int i = 0; i < 16; i++) begin
            if (m < need) begin
                m = {m[14:0], 1'b1};
            end
        end
        for (int i = 0; i < 16; i++) begin
            if (i >= width) begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/lfsr_sampler_fifo.sv
// Small synchronous FIFO buffering accepted samples; the head is read straight from storage.
// Flush empties it in one cycle and takes priority over push and pop.
module lfsr_sampler_fifo
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q;
    logic [AW-1:0]    wr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign count_o = cnt_q;
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    // Empty reads as zero so the output is clean straight out of reset.
    assign data_o  = empty_o ? '0 : mem_q[rd_q];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/lfsr_range_sampler.sv
// Mask-and-reject sampler turning LFSR states into uniform integers in [0, limit), buffered in a FIFO.
// Optional reject statistics are built when LFSR_SAMPLER_STATS_EN is defined.
module lfsr_range_sampler
    import lfsr_pkg::*;
#(
    parameter int OUT_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [LFSR_W-1:0] lfsr_state_i,
    input  logic              enable_i,
    input  logic [OUT_W-1:0]  limit_i,
    output logic [OUT_W-1:0]  rand_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [15:0]       reject_cnt_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    sampler_state_e   state_q;
    logic [OUT_W-1:0] limit_q;
    logic [OUT_W-1:0] mask_q;
    logic [OUT_W-1:0] mask_d;
    logic [15:0]      mask_full;
    logic [OUT_W-1:0] cand;
    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_empty;
    logic             fifo_full;
    logic             limit_nz;
    logic             limit_same;
    logic             run_ok;
    logic             take;
    logic             in_range;
    logic             push;
    logic             pop;
    logic             flush;
    logic             unused_ok;

    assign mask_full  = range_mask(16'(limit_i), OUT_W);
    assign mask_d     = mask_full[OUT_W-1:0];
    assign cand       = lfsr_state_i[OUT_W-1:0] & mask_q;

    assign limit_nz   = (limit_i != '0);
    assign limit_same = (limit_i == limit_q);
    assign run_ok     = (state_q == RUN) && enable_i && limit_nz && limit_same;

    // Space is judged on the registered count, so a same-cycle pop never frees a slot.
    assign take       = run_ok && (fifo_cnt < CNT_W'(FIFO_DEPTH));
    assign in_range   = (cand < limit_q);
    assign push       = take && in_range;
    assign pop        = ready_i && !fifo_empty;

    // Clear on the edge entering FLUSH so valid_o is already low during the FLUSH cycle.
    assign flush = (state_q == FLUSH)
                || ((state_q == IDLE) && enable_i && limit_nz)
                || ((state_q == RUN)  && enable_i && limit_nz && !limit_same);

    assign valid_o = !fifo_empty;

    lfsr_sampler_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (push),
        .data_i  (cand),
        .pop_i   (pop),
        .flush_i (flush),
        .data_o  (rand_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            limit_q <= '0;
            mask_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable_i && limit_nz) begin
                        state_q <= FLUSH;
                    end
                end
                FLUSH: begin
                    limit_q <= limit_i;
                    mask_q  <= mask_d;
                    state_q <= RUN;
                end
                RUN: begin
                    if (!enable_i || !limit_nz) begin
                        state_q <= IDLE;
                    end else if (!limit_same) begin
                        state_q <= FLUSH;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef LFSR_SAMPLER_STATS_EN
    logic        reject;
    logic [15:0] rej_q;

    // Only a candidate actually examined and out of range counts; a full FIFO skips the examination.
    assign reject = take && !in_range;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rej_q <= '0;
        end else if (state_q == FLUSH) begin
            rej_q <= '0;
        end else if (reject && (rej_q != 16'hFFFF)) begin
            rej_q <= rej_q + 16'd1;
        end
    end

    assign reject_cnt_o = rej_q;
`else
    assign reject_cnt_o = '0;
`endif

    assign unused_ok = ^{lfsr_state_i, mask_full, fifo_full};

endmodule

// File: tb/tb_lfsr_range_sampler.sv
// Directed bench for lfsr_range_sampler: reset, rejection, degenerate limit, backpressure,
// limit change, disable drain and asynchronous reset mid-operation.
module tb_lfsr_range_sampler;

    localparam int OUT_W = 8;
`ifdef LFSR_SAMPLER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk_i;
    logic             reset_i;
    logic [31:0]      lfsr_state_i;
    logic             enable_i;
    logic [OUT_W-1:0] limit_i;
    logic [OUT_W-1:0] rand_o;
    logic             valid_o;
    logic             ready_i;
    logic [15:0]      reject_cnt_o;

    int n_assert;
    int n_fail;

    lfsr_range_sampler #(
        .OUT_W      (OUT_W),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .lfsr_state_i (lfsr_state_i),
        .enable_i     (enable_i),
        .limit_i      (limit_i),
        .rand_o       (rand_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .reject_cnt_o (reject_cnt_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] exp_rej(input int n);
        return STATS ? 32'(n) : 32'd0;
    endfunction

    logic [7:0] bp_in  [5];
    logic [7:0] bp_out [3];

    initial begin
        n_assert     = 0;
        n_fail       = 0;
        reset_i      = 1'b0;
        lfsr_state_i = '0;
        enable_i     = 1'b0;
        limit_i      = '0;
        ready_i      = 1'b0;
        bp_in        = '{8'h13, 8'h25, 8'h07, 8'h39, 8'h0B};
        bp_out       = '{8'd5, 8'd7, 8'd9};

        // Reset must act before any clock edge.
        #2 reset_i = 1'b1;
        #1;
        check_eq("rst_valid", 32'(valid_o), 32'd0);
        check_eq("rst_rand", 32'(rand_o), 32'd0);
        check_eq("rst_rej", 32'(reject_cnt_o), 32'd0);
        tick();
        tick();
        reset_i = 1'b0;
        tick();
        check_eq("idle_valid", 32'(valid_o), 32'd0);

        // Rejection: 0xFD >= 200 is dropped, 0x42 accepted.
        limit_i = 8'd200; enable_i = 1'b1; ready_i = 1'b1; lfsr_state_i = 32'h0000_00FF;
        tick();
        tick();
        lfsr_state_i = 32'h00B4_1BFD;
        tick();
        check_eq("rej_valid", 32'(valid_o), 32'd0);
        check_eq("rej_cnt1", 32'(reject_cnt_o), exp_rej(1));
        lfsr_state_i = 32'h0000_0042;
        tick();
        check_eq("acc_valid", 32'(valid_o), 32'd1);
        check_eq("acc_rand", 32'(rand_o), 32'h42);
        check_eq("acc_rej", 32'(reject_cnt_o), exp_rej(1));
        lfsr_state_i = 32'h0000_00FF;
        tick();
        check_eq("acc_popped", 32'(valid_o), 32'd0);
        enable_i = 1'b0;
        tick();

        // Degenerate limit 1: every sample is 0, nothing rejected.
        limit_i = 8'd1; enable_i = 1'b1; ready_i = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 6; i++) begin
            lfsr_state_i = $urandom;
            tick();
            check_eq("deg_valid", 32'(valid_o), 32'd1);
            check_eq("deg_rand", 32'(rand_o), 32'd0);
        end
        check_eq("deg_rej", 32'(reject_cnt_o), 32'd0);
        enable_i = 1'b0;
        tick();
        check_eq("deg_drained", 32'(valid_o), 32'd0);

        // Backpressure: four entries fill the FIFO, the fifth is not taken.
        limit_i = 8'd16; enable_i = 1'b1; ready_i = 1'b0; lfsr_state_i = '0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            lfsr_state_i = {24'h0, bp_in[i]};
            tick();
            check_eq("bp_valid", 32'(valid_o), 32'd1);
            check_eq("bp_head", 32'(rand_o), 32'd3);
        end
        check_eq("bp_rej", 32'(reject_cnt_o), 32'd0);
        ready_i = 1'b1; enable_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("bp_drain", 32'(rand_o), 32'(bp_out[i]));
        end
        tick();
        check_eq("bp_empty", 32'(valid_o), 32'd0);

        // Limit change: queued entries are discarded, valid drops for the FLUSH cycle.
        limit_i = 8'd16; enable_i = 1'b1; ready_i = 1'b0; lfsr_state_i = '0;
        tick();
        tick();
        lfsr_state_i = 32'h01;
        tick();
        lfsr_state_i = 32'h02;
        tick();
        check_eq("lc_queued", 32'(valid_o), 32'd1);
        check_eq("lc_head", 32'(rand_o), 32'd1);
        limit_i = 8'd10; lfsr_state_i = 32'h0F;
        tick();
        check_eq("lc_flush_valid", 32'(valid_o), 32'd0);
        tick();
        check_eq("lc_empty", 32'(valid_o), 32'd0);
        lfsr_state_i = 32'h0C;
        tick();
        check_eq("lc_rej12", 32'(valid_o), 32'd0);
        lfsr_state_i = 32'h09;
        tick();
        check_eq("lc_acc9", 32'(rand_o), 32'd9);
        lfsr_state_i = 32'h0F;
        tick();
        lfsr_state_i = 32'h03;
        tick();
        check_eq("lc_head9", 32'(rand_o), 32'd9);
        check_eq("lc_rej", 32'(reject_cnt_o), exp_rej(2));
        ready_i = 1'b1; enable_i = 1'b0;
        tick();
        check_eq("lc_next3", 32'(rand_o), 32'd3);
        tick();
        check_eq("lc_drained", 32'(valid_o), 32'd0);

        // Disable with three entries queued: they drain, nothing new is pushed.
        limit_i = 8'd16; enable_i = 1'b1; ready_i = 1'b0; lfsr_state_i = '0;
        tick();
        tick();
        for (int i = 4; i < 7; i++) begin
            lfsr_state_i = 32'(i);
            tick();
        end
        check_eq("dis_head", 32'(rand_o), 32'd4);
        enable_i = 1'b0; lfsr_state_i = 32'h01;
        tick();
        check_eq("dis_hold_valid", 32'(valid_o), 32'd1);
        check_eq("dis_hold_rand", 32'(rand_o), 32'd4);
        lfsr_state_i = 32'h02;
        tick();
        ready_i = 1'b1;
        tick();
        check_eq("dis_d5", 32'(rand_o), 32'd5);
        tick();
        check_eq("dis_d6", 32'(rand_o), 32'd6);
        tick();
        check_eq("dis_empty", 32'(valid_o), 32'd0);

        // Asynchronous reset in the middle of operation.
        limit_i = 8'd10; enable_i = 1'b1; ready_i = 1'b0; lfsr_state_i = '0;
        tick();
        tick();
        lfsr_state_i = 32'h05;
        tick();
        lfsr_state_i = 32'h0E;
        tick();
        check_eq("mr_valid", 32'(valid_o), 32'd1);
        check_eq("mr_rand", 32'(rand_o), 32'd5);
        check_eq("mr_rej", 32'(reject_cnt_o), exp_rej(1));
        #3 reset_i = 1'b1;
        #1;
        check_eq("mr_rst_valid", 32'(valid_o), 32'd0);
        check_eq("mr_rst_rand", 32'(rand_o), 32'd0);
        check_eq("mr_rst_rej", 32'(reject_cnt_o), 32'd0);
        enable_i = 1'b0;
        tick();
        reset_i = 1'b0;
        tick();
        check_eq("post_rst_valid", 32'(valid_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
